pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives hold and clear enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three events:
- load-use hazards
- taken branches/jumps resolved in EX
- multi-cycle data-memory accesses, via a req/ready handshake with timeout

---
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX branch flush, and memory freeze with timeout.
// Optional saturating performance counters are built only when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memRead_EX,
    input  logic [4:0]       rd_EX,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1Used_ID,
    input  logic             rs2Used_ID,
    input  logic             branchTaken_EX,
    input  logic             memReq_MEM,
    input  logic             memReady,
    output logic             stallPC,
    output logic             stallIF_ID,
    output logic             flushIF_ID,
    output logic             flushID_EX,
    output logic             stallID_EX,
    output logic             stallEX_MEM,
    output logic             flushMEM_WB,
    output logic             memError,
    output logic [CNT_W-1:0] loadUseCount,
    output logic [CNT_W-1:0] memWaitCount,
    output logic [CNT_W-1:0] flushCount
);

    localparam int unsigned WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    state_e              state_r, state_next;
    logic [WCNT_W-1:0]   wait_cnt_r, wait_cnt_next;
    logic                mem_error_r, mem_error_next;
    logic                mem_stall_s;
    logic                load_use_s;
    logic                freeze_s;
    logic                br_flush_s;
    logic                lu_stall_s;

    assign mem_stall_s = memReq_MEM & ~memReady;
    assign load_use_s  = memRead_EX & (rd_EX != 5'd0) &
                         ((rs1Used_ID & (rs1_ID == rd_EX)) | (rs2Used_ID & (rs2_ID == rd_EX)));

    // State, wait counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= {WCNT_W{1'b0}};
            mem_error_r <= 1'b0;
        end else begin
            state_r     <= state_next;
            wait_cnt_r  <= wait_cnt_next;
            mem_error_r <= mem_error_next;
        end
    end

    // Next-state and hazard decisions; memory freeze outranks branch flush, which outranks load-use.
    always_comb begin
        state_next     = state_r;
        wait_cnt_next  = wait_cnt_r;
        mem_error_next = mem_error_r;
        freeze_s       = 1'b0;
        br_flush_s     = 1'b0;
        lu_stall_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_s) begin
                    freeze_s      = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = {{(WCNT_W-1){1'b0}}, 1'b1};
                end else if (branchTaken_EX) begin
                    br_flush_s = 1'b1;
                end else if (load_use_s) begin
                    lu_stall_s = 1'b1;
                end else begin
                    lu_stall_s = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                if (memReady) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = {WCNT_W{1'b0}};
                end else begin
                    freeze_s = 1'b1;
                    if (wait_cnt_r == WAIT_MAX) begin
                        state_next     = ST_ERROR;
                        mem_error_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_ERROR: begin
                freeze_s       = 1'b1;
                mem_error_next = 1'b1;
            end
            default: begin
                // An illegal encoding is treated as a fatal memory fault.
                freeze_s       = 1'b1;
                state_next     = ST_ERROR;
                mem_error_next = 1'b1;
            end
        endcase
    end

    assign stallPC     = rst_n & (freeze_s | lu_stall_s);
    assign stallIF_ID  = rst_n & (freeze_s | lu_stall_s);
    assign flushIF_ID  = rst_n & br_flush_s;
    assign flushID_EX  = rst_n & (br_flush_s | lu_stall_s);
    assign stallID_EX  = rst_n & freeze_s;
    assign stallEX_MEM = rst_n & freeze_s;
    assign flushMEM_WB = rst_n & freeze_s;
    assign memError    = mem_error_r;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] lu_cnt_r, mw_cnt_r, fl_cnt_r;
    logic             mw_evt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_inc = v;
        end
    endfunction

    assign mw_evt_s = freeze_s & ((state_r == ST_RUN) | (state_r == ST_MEM_WAIT));

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_r <= {CNT_W{1'b0}};
            mw_cnt_r <= {CNT_W{1'b0}};
            fl_cnt_r <= {CNT_W{1'b0}};
        end else begin
            lu_cnt_r <= sat_inc(lu_cnt_r, lu_stall_s);
            mw_cnt_r <= sat_inc(mw_cnt_r, mw_evt_s);
            fl_cnt_r <= sat_inc(fl_cnt_r, br_flush_s);
        end
    end

    assign loadUseCount = lu_cnt_r;
    assign memWaitCount = mw_cnt_r;
    assign flushCount   = fl_cnt_r;
`else
    assign loadUseCount = {CNT_W{1'b0}};
    assign memWaitCount = {CNT_W{1'b0}};
    assign flushCount   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, corner-case sequences and a random run against a reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TMO   = 4;
    localparam int unsigned CNT_W = 32;
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1101000;
    localparam logic [6:0] BR   = 7'b0011000;
    localparam logic [6:0] FRZ  = 7'b1100111;

    logic clk, rst_n;
    logic memRead_EX, rs1Used_ID, rs2Used_ID, branchTaken_EX, memReq_MEM, memReady;
    logic [4:0] rd_EX, rs1_ID, rs2_ID;
    logic stallPC, stallIF_ID, flushIF_ID, flushID_EX, stallID_EX, stallEX_MEM, flushMEM_WB, memError;
    logic [CNT_W-1:0] loadUseCount, memWaitCount, flushCount;
    logic [6:0] outs;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit     m_err, m_pend;
    int     m_frz;
    longint m_lu, m_mw, m_fl;
    longint cmax = (longint'(1) << CNT_W) - 1;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .memRead_EX(memRead_EX), .rd_EX(rd_EX), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1Used_ID(rs1Used_ID), .rs2Used_ID(rs2Used_ID), .branchTaken_EX(branchTaken_EX),
        .memReq_MEM(memReq_MEM), .memReady(memReady),
        .stallPC(stallPC), .stallIF_ID(stallIF_ID), .flushIF_ID(flushIF_ID), .flushID_EX(flushID_EX),
        .stallID_EX(stallID_EX), .stallEX_MEM(stallEX_MEM), .flushMEM_WB(flushMEM_WB),
        .memError(memError), .loadUseCount(loadUseCount), .memWaitCount(memWaitCount),
        .flushCount(flushCount)
    );

    assign outs = {stallPC, stallIF_ID, flushIF_ID, flushID_EX, stallID_EX, stallEX_MEM, flushMEM_WB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mr;
        logic [4:0] rd, r1, r2;
        logic       u1, u2, br, req, rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic longint exp_cnt(input longint v);
`ifdef HAZARD_PERF_COUNTERS_EN
        return v;
`else
        return 0 + (v - v);
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, g, e, $time);
        end
    endtask

    task automatic chk_counters();
        chk("loadUseCount", 64'(loadUseCount), exp_cnt(m_lu));
        chk("memWaitCount", 64'(memWaitCount), exp_cnt(m_mw));
        chk("flushCount",   64'(flushCount),   exp_cnt(m_fl));
    endtask

    task automatic clear_inputs();
        memRead_EX = 1'b0; rd_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd0;
        rs1Used_ID = 1'b0; rs2Used_ID = 1'b0; branchTaken_EX = 1'b0;
        memReq_MEM = 1'b0; memReady = 1'b0;
    endtask

    // Reset asserted dly time units after a falling edge, with hazard-provoking inputs applied.
    task automatic do_reset(input int dly);
        @(negedge clk);
        #(dly);
        rst_n = 1'b0;
        memRead_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; rs1Used_ID = 1'b1;
        branchTaken_EX = 1'b1; memReq_MEM = 1'b1; memReady = 1'b0;
        #1;
        m_err = 1'b0; m_pend = 1'b0; m_frz = 0; m_lu = 0; m_mw = 0; m_fl = 0;
        chk("rst_outs", 64'(outs), 64'(NONE));
        chk("rst_memError", 64'(memError), 64'd0);
        chk_counters();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check against the model, clock, then advance the model.
    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic br, input logic req, input logic rdy,
                        output logic [6:0] got);
        logic [6:0] e;
        logic lu;
        @(negedge clk);
        memRead_EX = mr; rd_EX = rd; rs1_ID = r1; rs2_ID = r2;
        rs1Used_ID = u1; rs2Used_ID = u2; branchTaken_EX = br;
        memReq_MEM = req; memReady = rdy;
        #1;
        lu = mr && (rd != 5'd0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
        if (m_err)              e = FRZ;
        else if (m_pend)        e = rdy ? NONE : FRZ;
        else if (req && !rdy)   e = FRZ;
        else if (br)            e = BR;
        else if (lu)            e = LU;
        else                    e = NONE;
        got = outs;
        chk("model_outs", 64'(got), 64'(e));
        chk("model_memError", 64'(memError), 64'(m_err));
        chk_counters();
        @(posedge clk);
        if (m_err) begin
        end else if (m_pend) begin
            if (rdy) begin
                m_pend = 1'b0;
            end else begin
                m_frz++;
                if (m_mw < cmax) m_mw++;
                if (m_frz >= TMO) begin
                    m_err = 1'b1; m_pend = 1'b0;
                end
            end
        end else if (req && !rdy) begin
            m_pend = 1'b1; m_frz = 1;
            if (m_mw < cmax) m_mw++;
        end else if (br) begin
            if (m_fl < cmax) m_fl++;
        end else if (lu) begin
            if (m_lu < cmax) m_lu++;
        end
    endtask

    logic [6:0] got;

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        //            mr    rd     rs1    rs2    u1    u2    br    req   rdy   exp
        vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE};
        vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NONE};
        vecs[3] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU};
        vecs[4] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NONE};
        vecs[5] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NONE};
        vecs[6] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, BR};
        vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR};
        vecs[8] = '{1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, LU};
        vecs[9] = '{1'b1, 5'd3, 5'd4, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NONE};

        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].mr, vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].u1, vecs[i].u2,
                 vecs[i].br, vecs[i].req, vecs[i].rdy, got);
            chk($sformatf("vec%0d", i), 64'(got), 64'(vecs[i].exp));
        end

        // memory wait: three frozen cycles, released on the ready cycle, then back in RUN
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, got);
            chk("memwait_frz", 64'(got), 64'(FRZ));
        end
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, got);
        chk("memwait_release", 64'(got), 64'(NONE));
        step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, got);
        chk("memwait_run_lu", 64'(got), 64'(LU));
`ifdef HAZARD_PERF_COUNTERS_EN
        chk("memwait_cnt3", 64'(memWaitCount), 64'd3);
`endif

        // branch held across a freeze flushes only after the ready cycle
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, got);
        chk("brfrz_0", 64'(got), 64'(FRZ));
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, got);
        chk("brfrz_1", 64'(got), 64'(FRZ));
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, got);
        chk("brfrz_ready", 64'(got), 64'(NONE));
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, got);
        chk("brfrz_flush", 64'(got), 64'(BR));
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, got);
        chk("brfrz_after", 64'(got), 64'(NONE));

        // back-to-back access, then a timeout into ERROR
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, got);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, got);
        chk("b2b_release", 64'(got), 64'(NONE));
        for (int i = 0; i < int'(TMO); i++) begin
            step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, got);
            chk("tmo_frz", 64'(got), 64'(FRZ));
            if (i < int'(TMO) - 1) chk("tmo_noerr", 64'(memError), 64'd0);
        end
        @(negedge clk);
        #1;
        chk("tmo_memError", 64'(memError), 64'd1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, got);
        chk("err_hold", 64'(got), 64'(FRZ));
        step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, got);
        chk("err_hold2", 64'(got), 64'(FRZ));
        do_reset(0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, got);
        chk("post_err_idle", 64'(got), 64'(NONE));
        chk("post_err_memError", 64'(memError), 64'd0);

        // asynchronous reset in the middle of a wait
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, got);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, got);
        do_reset(3);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, got);
        chk("async_rst_run", 64'(got), 64'(NONE));

        // randomized run against the model
        for (int n = 0; n < 400; n++) begin
            if (m_err && ($urandom_range(3, 0) == 0)) do_reset(int'($urandom_range(3, 0)));
            step(1'($urandom_range(1, 0)), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                 5'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(3, 0) == 0), 1'($urandom_range(2, 0) == 0),
                 1'($urandom_range(3, 0) != 0), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
